// File: rtl/riscv_pkg.sv
// Shared fetch-side constants and the fetch FSM state encoding.
package riscv_pkg;
  localparam int ILEN = 32;
  localparam int PC_STEP = 4;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head is valid only while count != 0.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic             full, empty, do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited memory requests, in-order response buffer,
// redirect handling that discards responses to requests issued before the redirect.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              BITS     = 32,
  parameter logic [BITS-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [BITS-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [BITS-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instruction,
  output logic [BITS-1:0] instr_pc
);
  localparam int CW = $clog2(DEPTH+1);

  fetch_state_e         state, state_nxt;
  logic [BITS-1:0]      pc;
  logic [CW-1:0]        inflight, inflight_nxt, stale, stale_nxt;
  logic [CW-1:0]        buf_count, aq_count;
  logic [ILEN+BITS-1:0] buf_head;
  logic [BITS-1:0]      aq_head;
  logic                 req_hs, rsp_take, rsp_keep, buf_pop;

  // Credits cover both outstanding requests and buffered words, so the buffer never overflows.
  always_comb begin
    imem_req_valid = (state == FETCH) &&
                     (({1'b0, inflight} + {1'b0, buf_count}) < (CW+1)'(DEPTH));
    imem_req_addr  = pc;
  end

  assign req_hs   = imem_req_valid && imem_req_ready;
  assign rsp_take = imem_rsp_valid && (inflight != '0);
  assign rsp_keep = rsp_take && (stale == '0) && !redirect_valid && (aq_count != '0);
  assign buf_pop  = instr_valid && instr_ready && !redirect_valid;

  assign instr_valid = (buf_count != '0);
  assign instruction = instr_valid ? buf_head[BITS +: ILEN] : '0;
  assign instr_pc    = instr_valid ? buf_head[BITS-1:0]     : '0;

  // Everything still outstanding after a redirect belongs to the old path.
  always_comb begin
    inflight_nxt = inflight;
    if (req_hs && !rsp_take)      inflight_nxt = inflight + 1'b1;
    else if (!req_hs && rsp_take) inflight_nxt = inflight - 1'b1;
    stale_nxt = stale;
    if (redirect_valid)               stale_nxt = inflight_nxt;
    else if (rsp_take && stale != '0) stale_nxt = stale - 1'b1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (redirect_valid && stale_nxt != '0) state_nxt = DRAIN;
      DRAIN:   if (stale_nxt == '0) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      inflight <= '0;
      stale    <= '0;
    end else begin
      inflight <= inflight_nxt;
      stale    <= stale_nxt;
      if (redirect_valid) pc <= redirect_pc & ~BITS'(3);
      else if (req_hs)    pc <= pc + BITS'(PC_STEP);
    end
  end

  fetch_fifo #(.WIDTH(ILEN+BITS), .DEPTH(DEPTH)) u_ibuf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_keep),
    .pop   (buf_pop),
    .flush (redirect_valid),
    .din   ({imem_rsp_data, aq_head}),
    .head  (buf_head),
    .count (buf_count)
  );

  // PCs of live (non-stale) requests, matched to responses in order.
  fetch_fifo #(.WIDTH(BITS), .DEPTH(DEPTH)) u_addr_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_hs && !redirect_valid),
    .pop   (rsp_keep),
    .flush (redirect_valid),
    .din   (pc),
    .head  (aq_head),
    .count (aq_count)
  );

  rsp_needs_inflight: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> inflight != '0);
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a queue-based reference model and a 1-cycle memory.
module tb_fetch_unit;
  localparam int          BITS   = 32;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0;
  localparam logic [31:0] KEY    = 32'hA5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instruction, instr_pc;

  always #5 clk = ~clk;

  fetch_unit #(.BITS(BITS), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc)
  );

  typedef struct { logic [31:0] addr; int epoch; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ins_t;

  req_t        mem_q[$];   // accepted requests not yet answered
  ins_t        exp_q[$];   // words decode must see, in order
  int          epoch   = 0;
  logic        started = 1'b0;
  logic [31:0] exp_req = RST_PC;
  logic        rsp_en  = 1'b1;
  int          total   = 0;
  int          passed  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Memory answers the oldest request one cycle after acceptance, data = addr ^ KEY.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && rsp_en && mem_q.size() != 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_q[0].addr ^ KEY;
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
    end
  end

  // Compare on every falling edge, then advance the model to the next rising edge.
  initial begin
    forever begin : mdl
      logic exp_rv, hs;
      int   stale_n;
      req_t r;
      @(negedge clk);
      if (!rst_n) begin
        mem_q.delete(); exp_q.delete();
        started = 1'b0; exp_req = RST_PC; epoch = 0;
      end else begin
        stale_n = 0;
        foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale_n++;
        exp_rv = started && stale_n == 0 && (mem_q.size() + exp_q.size() < DEPTH);
        chk("req_valid", imem_req_valid, exp_rv);
        if (exp_rv) chk("req_addr", imem_req_addr, exp_req);
        chk("instr_valid", instr_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          chk("instr_pc", instr_pc, exp_q[0].pc);
          chk("instruction", instruction, exp_q[0].data);
        end
        hs = exp_rv && imem_req_ready;
        if (!started) begin
          started = 1'b1;
        end else if (redirect_valid) begin
          if (imem_rsp_valid) r = mem_q.pop_front();
          if (hs) mem_q.push_back('{exp_req, epoch});
          epoch++;
          exp_q.delete();
          exp_req = redirect_pc & ~32'h3;
        end else begin
          if (exp_q.size() != 0 && instr_ready) exp_q.pop_front();
          if (imem_rsp_valid) begin
            r = mem_q.pop_front();
            if (r.epoch == epoch) exp_q.push_back('{r.addr, r.addr ^ KEY});
          end
          if (hs) begin
            mem_q.push_back('{exp_req, epoch});
            exp_req = exp_req + 32'd4;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_req(output logic [31:0] a);
    a = '1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin a = imem_req_addr; return; end
    end
    total++;
    $display("FAIL wait_req: no request handshake within 64 cycles, expected one");
  endtask

  task automatic wait_instr(output logic [31:0] p, output logic [31:0] d);
    p = '1; d = '1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (instr_valid && instr_ready) begin p = instr_pc; d = instruction; return; end
    end
    total++;
    $display("FAIL wait_instr: no instruction within 64 cycles, expected one");
  endtask

  initial begin
    logic [31:0] a, p, d;
    logic        both;
    imem_req_ready = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst req_valid", imem_req_valid, 1'b0);
    chk("rst req_addr", imem_req_addr, RST_PC);
    chk("rst instr_valid", instr_valid, 1'b0);
    chk("rst instruction", instruction, 32'h0);
    chk("rst instr_pc", instr_pc, 32'h0);
    @(posedge clk);
    step();
    rst_n = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1;

    // 1: streaming from reset
    wait_req(a);      chk("t1 first addr", a, 32'h0);
    wait_instr(p, d); chk("t1 pc0", p, 32'h0); chk("t1 data0", d, 32'hA5);
    wait_instr(p, d); chk("t1 pc1", p, 32'h4);
    wait_instr(p, d); chk("t1 pc2", p, 32'h8);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk); chk("t1 no gap", instr_valid, 1'b1);
    end

    // 2: decode backpressure
    step(); instr_ready = 1'b0;
    repeat (6) step();
    @(negedge clk);
    chk("t2 credits exhausted", imem_req_valid, 1'b0);
    chk("t2 word held", instr_valid, 1'b1);
    step(); instr_ready = 1'b1;
    repeat (10) step();

    // 3: redirect with two requests in flight
    imem_req_ready = 1'b0;
    repeat (6) step();
    rsp_en = 1'b0; imem_req_ready = 1'b1;
    step(); step();
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h104;
    step();
    redirect_valid = 1'b0; rsp_en = 1'b1; imem_req_ready = 1'b1;
    @(negedge clk);   chk("t3 draining", imem_req_valid, 1'b0);
    wait_req(a);      chk("t3 addr", a, 32'h104);
    wait_instr(p, d); chk("t3 pc", p, 32'h104); chk("t3 data", d, 32'h1A1);

    // 4: redirect coinciding with request handshake and response
    step();
    both = 1'b0;
    for (int n = 0; n < 32; n++) begin
      if (imem_req_valid && imem_rsp_valid) begin both = 1'b1; break; end
      step();
    end
    chk("t4 coincident cycle found", both, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    step(); redirect_valid = 1'b0;
    wait_req(a);      chk("t4 addr", a, 32'h200);
    wait_instr(p, d); chk("t4 pc", p, 32'h200); chk("t4 data", d, 32'h2A5);

    // 6: memory not ready holds the request
    step(); imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300;
    step(); redirect_valid = 1'b0;
    repeat (4) step();
    for (int n = 0; n < 4; n++) begin
      @(negedge clk); chk("t6 req held", {imem_req_valid, imem_req_addr}, {1'b1, 32'h300});
    end
    step(); imem_req_ready = 1'b1;
    wait_req(a); chk("t6 addr0", a, 32'h300);
    wait_req(a); chk("t6 addr1", a, 32'h304);

    // 5: pc wrap, then reset mid-stream
    step(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(); redirect_valid = 1'b0;
    wait_req(a);      chk("t5 top addr", a, 32'hFFFF_FFFC);
    wait_req(a);      chk("t5 wrap addr", a, 32'h0);
    wait_instr(p, d); chk("t5 top pc", p, 32'hFFFF_FFFC); chk("t5 top data", d, 32'hFFFF_FF59);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("t5 rst instr_valid", instr_valid, 1'b0);
    chk("t5 rst req_valid", imem_req_valid, 1'b0);
    chk("t5 rst req_addr", imem_req_addr, RST_PC);
    chk("t5 rst outputs", {instruction, instr_pc}, 64'h0);
    step(); step();
    rst_n = 1'b1;
    wait_req(a);      chk("t5 restart addr", a, RST_PC);
    wait_instr(p, d); chk("t5 restart pc", p, RST_PC);
    repeat (3) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
